// File: rtl/conv1_compute_filter.sv
// conv1_compute_filter: three-stage pipelined signed dot product of one
// pixel window against one filter (NUM_PIXELS taps, FILTER_ROWS rows).
//   stage 1: per-tap full-precision signed products
//   stage 2: one sign-extended partial sum per filter row
//   stage 3: sign-extended sum of the row partials -> conv1_compute_filter_o
// One window per cycle, no handshake, fixed 3-edge latency.
// Optional build macro CONV1_FILT_RELU_EN: stage 3 clamps negative sums to 0.
// Reset (conv1_filt_rst_b) is asynchronous and active-high despite its name.
module conv1_compute_filter #(
  parameter int FILTER_ROWS   = 5,
  parameter int PIXEL_WIDTH   = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int NUM_PIXELS    = 25,
  parameter int NUM_WEIGHTS   = 25,
  parameter int OPERAND_WIDTH = 8,
  parameter int OUTPUT_WIDTH  = 22
) (
  input  logic                                          conv1_filt_clk,
  input  logic                                          conv1_filt_rst_b,
  input  logic signed [NUM_PIXELS-1:0][PIXEL_WIDTH-1:0]   pxl_filt_vals_i,
  input  logic signed [NUM_WEIGHTS-1:0][WEIGHT_WIDTH-1:0] weight_vals_i,
  output logic signed [OUTPUT_WIDTH-1:0]                conv1_compute_filter_o
);

  localparam int PROD_W = 2 * OPERAND_WIDTH;
  localparam int COLS   = NUM_PIXELS / FILTER_ROWS;

  logic signed [PROD_W-1:0]       prod_d [NUM_PIXELS];
  logic signed [PROD_W-1:0]       prod_q [NUM_PIXELS];
  logic signed [OUTPUT_WIDTH-1:0] row_d  [FILTER_ROWS];
  logic signed [OUTPUT_WIDTH-1:0] row_q  [FILTER_ROWS];
  logic signed [OUTPUT_WIDTH-1:0] sum_d;
  logic signed [OUTPUT_WIDTH-1:0] res_d;

  // Per-tap products; element selects of a packed array are unsigned, so
  // each operand is re-signed and sign-extended before multiplying.
  always_comb begin
    for (int k = 0; k < NUM_PIXELS; k++) begin
      prod_d[k] = PROD_W'($signed(pxl_filt_vals_i[k])) *
                  PROD_W'($signed(weight_vals_i[k]));
    end
  end

  // Stage 1 register: all products.
  always_ff @(posedge conv1_filt_clk or posedge conv1_filt_rst_b) begin
    if (conv1_filt_rst_b) begin
      for (int k = 0; k < NUM_PIXELS; k++) prod_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_PIXELS; k++) prod_q[k] <= prod_d[k];
    end
  end

  // Row partial sums, accumulated at full output width so nothing can wrap.
  always_comb begin
    for (int r = 0; r < FILTER_ROWS; r++) begin
      row_d[r] = '0;
      for (int c = 0; c < COLS; c++) begin
        row_d[r] = row_d[r] + OUTPUT_WIDTH'(prod_q[r*COLS + c]);
      end
    end
  end

  // Stage 2 register: row partial sums.
  always_ff @(posedge conv1_filt_clk or posedge conv1_filt_rst_b) begin
    if (conv1_filt_rst_b) begin
      for (int r = 0; r < FILTER_ROWS; r++) row_q[r] <= '0;
    end else begin
      for (int r = 0; r < FILTER_ROWS; r++) row_q[r] <= row_d[r];
    end
  end

  // Final sum of row partials, with optional ReLU clamp.
  always_comb begin
    sum_d = '0;
    for (int r = 0; r < FILTER_ROWS; r++) sum_d = sum_d + row_q[r];
`ifdef CONV1_FILT_RELU_EN
    res_d = sum_d[OUTPUT_WIDTH-1] ? '0 : sum_d;
`else
    res_d = sum_d;
`endif
  end

  // Stage 3 register: the result.
  always_ff @(posedge conv1_filt_clk or posedge conv1_filt_rst_b) begin
    if (conv1_filt_rst_b) conv1_compute_filter_o <= '0;
    else                  conv1_compute_filter_o <= res_d;
  end

endmodule

// File: tb/tb_conv1_compute_filter.sv
// Testbench for conv1_compute_filter: a driver issues windows and pushes the
// reference result into exp_q; a monitor tracks which cycles carry issued
// windows and compares the output 3 edges after each was sampled.
module tb_conv1_compute_filter;

  localparam int NP = 25;
  localparam int PW = 8;
  localparam int W  = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [NP-1:0][PW-1:0] pxl = '0;
  logic signed [NP-1:0][PW-1:0] wt  = '0;
  logic signed [W-1:0]          dout;

  logic [W-1:0] exp_q[$];
  int cur_p [NP];
  int cur_w [NP];
  logic drv_valid   = 1'b0;
  logic expect_zero = 1'b0;
  logic end_req     = 1'b0;
  int check_n = 0;
  int fail_n  = 0;

  conv1_compute_filter dut (
    .conv1_filt_clk        (clk),
    .conv1_filt_rst_b      (rst),
    .pxl_filt_vals_i       (pxl),
    .weight_vals_i         (wt),
    .conv1_compute_filter_o(dout)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: plain signed dot product, optional clamp at zero.
  function automatic int model();
    int acc = 0;
    for (int k = 0; k < NP; k++) acc += cur_p[k] * cur_w[k];
`ifdef CONV1_FILT_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  // Driver: apply cur_p/cur_w as the next window and record its result.
  task automatic issue();
    @(posedge clk); #1;
    for (int k = 0; k < NP; k++) begin
      pxl[k] = PW'(cur_p[k]);
      wt[k]  = PW'(cur_w[k]);
    end
    drv_valid = 1'b1;
    exp_q.push_back(W'(model()));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pxl = '0;
    wt  = '0;
    drv_valid = 1'b0;
  endtask

  task automatic fill(input int p, input int w);
    for (int k = 0; k < NP; k++) begin
      cur_p[k] = p;
      cur_w[k] = w;
    end
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Monitor: reset-zero checks, scoreboard compares, idle-zero checks, report.
  logic [2:0] pipe = '0;
  logic [W-1:0] exp_v;
  always begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pipe = '0;
      #1;
      check_n++;
      if (dout !== '0) begin
        fail_n++;
        $display("FAIL reset_zero: got %0d want 0 at %0t", $signed(dout), $time);
      end
    end else begin
      pipe = {pipe[1:0], drv_valid};
      #2;
      if (pipe[2]) begin
        check_n++;
        if (exp_q.size() == 0) begin
          fail_n++;
          $display("FAIL scoreboard_empty: got %0d with no expected value", $signed(dout));
        end else begin
          exp_v = exp_q.pop_front();
          if (dout !== exp_v) begin
            fail_n++;
            $display("FAIL result: got %0d want %0d at %0t", $signed(dout), $signed(exp_v), $time);
          end
        end
      end else if (expect_zero) begin
        check_n++;
        if (dout !== '0) begin
          fail_n++;
          $display("FAIL idle_zero: got %0d want 0 at %0t", $signed(dout), $time);
        end
      end
      if (end_req) begin
        check_n++;
        if (exp_q.size() != 0) begin
          fail_n++;
          $display("FAIL drain: got %0d pending results want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", check_n, fail_n);
        $finish;
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int vals [5];
    vals[0] = -128; vals[1] = -1; vals[2] = 0; vals[3] = 1; vals[4] = 127;

    // Reset held with arbitrary inputs: output must stay 0.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NP; k++) begin
        pxl[k] = PW'(rnd8());
        wt[k]  = PW'(rnd8());
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pxl = '0;
    wt  = '0;
    expect_zero = 1'b1;
    for (int i = 0; i < 3; i++) idle();
    expect_zero = 1'b0;

    // -1 * -1 everywhere, held constant: 25 every cycle.
    fill(-1, -1);
    for (int i = 0; i < 5; i++) issue();
    // Largest magnitude positive result.
    fill(-128, -128);
    for (int i = 0; i < 3; i++) issue();
    // Largest magnitude negative result (clamped when ReLU is built in).
    fill(127, -128);
    for (int i = 0; i < 3; i++) issue();

    // Single tap 12 (3 * -5) alternating with an all-ones window.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        fill(0, 0);
        cur_p[12] = 3;
        cur_w[12] = -5;
      end else begin
        fill(1, 1);
      end
      issue();
    end

    // Random windows, back-to-back with occasional bubbles.
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < NP; k++) begin
        cur_p[k] = rnd8();
        cur_w[k] = rnd8();
      end
      issue();
      if ($urandom_range(0, 7) == 0) idle();
    end

    // Random mixes of extreme values.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < NP; k++) begin
        cur_p[k] = vals[$urandom_range(0, 4)];
        cur_w[k] = vals[$urandom_range(0, 4)];
      end
      issue();
    end

    // Reset between edges with the pipeline full: in-flight windows dropped.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NP; k++) begin
        cur_p[k] = rnd8();
        cur_w[k] = rnd8();
      end
      issue();
    end
    @(posedge clk); #3;
    rst = 1'b1;
    drv_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NP; k++) begin
        pxl[k] = PW'(rnd8());
        wt[k]  = PW'(rnd8());
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pxl = '0;
    wt  = '0;
    expect_zero = 1'b1;
    for (int i = 0; i < 3; i++) idle();
    expect_zero = 1'b0;

    // New data after the mid-run reset.
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NP; k++) begin
        cur_p[k] = rnd8();
        cur_w[k] = rnd8();
      end
      issue();
    end

    for (int i = 0; i < 5; i++) idle();
    end_req = 1'b1;
  end

endmodule
